// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: turns I-cache block fills and LSB loads/stores into
// per-byte cycles on a byte-wide RAM bus, alternating grants under contention.
module mem_arbiter #(
   parameter int unsigned BLK_BYTES = 64,
   parameter logic [1:0]  IO_MASK   = 2'b11
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rdy,
   input  logic                   rollback,
   input  logic                   if_valid,
   input  logic [31:0]            if_addr,
   output logic                   if_done,
   output logic [8*BLK_BYTES-1:0] if_data,
   input  logic                   lsb_valid,
   input  logic                   lsb_wr,
   input  logic [31:0]            lsb_addr,
   input  logic [1:0]             lsb_size,
   input  logic [31:0]            lsb_wdata,
   output logic                   lsb_done,
   output logic [31:0]            lsb_rdata,
   input  logic [7:0]             mem_din,
   output logic [7:0]             mem_dout,
   output logic [31:0]            mem_a,
   output logic                   mem_wr,
   input  logic                   io_buffer_full
);

   localparam int unsigned CntW = $clog2(BLK_BYTES + 1);
   localparam int unsigned IdxW = $clog2(8 * BLK_BYTES);

   typedef enum logic [2:0] {StIdle, StIfRead, StLsRead, StLsWrite, StDone} state_e;
   typedef enum logic {GrantIf, GrantLsb} grant_e;

   state_e                 state_q, state_d;
   grant_e                 last_grant_q, last_grant_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [CntW-1:0]        len_q, len_d;
   logic [31:0]            addr_q, addr_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [31:0]            mem_a_q, mem_a_d;
   logic [7:0]             mem_dout_q, mem_dout_d;
   logic                   mem_wr_q, mem_wr_d;
   logic                   if_done_q, if_done_d;
   logic                   lsb_done_q, lsb_done_d;
   logic [8*BLK_BYTES-1:0] if_data_q, if_data_d;
   logic [31:0]            lsb_rdata_q, lsb_rdata_d;

   logic                   io_store_blocked, if_elig, lsb_elig, grant_lsb, grant_if;
   logic [CntW-1:0]        req_len;
   logic [CntW-1:0]        byte_idx;
   logic [IdxW-1:0]        if_bit;
   logic [4:0]             ls_bit, wr_bit;

   always_comb begin
      io_store_blocked = lsb_wr && (lsb_addr[17:16] == IO_MASK) && io_buffer_full;
      if_elig          = if_valid;
      // A load about to be flushed must not start this cycle.
      lsb_elig         = lsb_valid && !io_store_blocked && !(rollback && !lsb_wr);
      grant_lsb        = lsb_elig && (!if_elig || (last_grant_q == GrantIf));
      grant_if         = if_elig && !grant_lsb;
      unique case (lsb_size)
         2'd0:    req_len = CntW'(1);
         2'd1:    req_len = CntW'(2);
         default: req_len = CntW'(4);
      endcase
      // mem_din carries the byte addressed in the previous cycle, i.e. byte cnt-1.
      byte_idx = cnt_q - CntW'(1);
      if_bit   = IdxW'({byte_idx, 3'b000});
      ls_bit   = {byte_idx[1:0], 3'b000};
      wr_bit   = {cnt_q[1:0], 3'b000};
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      len_d        = len_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      mem_a_d      = mem_a_q;
      mem_dout_d   = mem_dout_q;
      mem_wr_d     = mem_wr_q;
      if_done_d    = 1'b0;
      lsb_done_d   = 1'b0;
      if_data_d    = if_data_q;
      lsb_rdata_d  = lsb_rdata_q;

      unique case (state_q)
         StIdle: begin
            if (grant_if) begin
               state_d      = StIfRead;
               last_grant_d = GrantIf;
               addr_d       = if_addr;
               mem_a_d      = if_addr;
               cnt_d        = CntW'(1);
               mem_wr_d     = 1'b0;
            end else if (grant_lsb) begin
               last_grant_d = GrantLsb;
               addr_d       = lsb_addr;
               mem_a_d      = lsb_addr;
               cnt_d        = CntW'(1);
               len_d        = req_len;
               wdata_d      = lsb_wdata;
               if (lsb_wr) begin
                  state_d    = StLsWrite;
                  mem_wr_d   = 1'b1;
                  mem_dout_d = lsb_wdata[7:0];
               end else begin
                  state_d     = StLsRead;
                  mem_wr_d    = 1'b0;
                  lsb_rdata_d = '0;
               end
            end
         end
         StIfRead: begin
            if_data_d[if_bit +: 8] = mem_din;
            if (cnt_q == CntW'(BLK_BYTES)) begin
               if_done_d = 1'b1;
               state_d   = StDone;
            end else begin
               mem_a_d = addr_q + 32'(cnt_q);
               cnt_d   = cnt_q + CntW'(1);
            end
         end
         StLsRead: begin
            if (rollback) begin
               state_d  = StIdle;
               mem_wr_d = 1'b0;
               cnt_d    = '0;
            end else begin
               lsb_rdata_d[ls_bit +: 8] = mem_din;
               if (cnt_q == len_q) begin
                  lsb_done_d = 1'b1;
                  state_d    = StDone;
               end else begin
                  mem_a_d = addr_q + 32'(cnt_q);
                  cnt_d   = cnt_q + CntW'(1);
               end
            end
         end
         StLsWrite: begin
            if (cnt_q == len_q) begin
               mem_wr_d   = 1'b0;
               lsb_done_d = 1'b1;
               state_d    = StDone;
            end else begin
               mem_a_d    = addr_q + 32'(cnt_q);
               mem_dout_d = wdata_q[wr_bit +: 8];
               cnt_d      = cnt_q + CntW'(1);
            end
         end
         StDone: begin
            mem_wr_d = 1'b0;
            cnt_d    = '0;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= StIdle;
         last_grant_q <= GrantIf;
         cnt_q        <= '0;
         len_q        <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mem_a_q      <= '0;
         mem_dout_q   <= '0;
         mem_wr_q     <= 1'b0;
         if_done_q    <= 1'b0;
         lsb_done_q   <= 1'b0;
         if_data_q    <= '0;
         lsb_rdata_q  <= '0;
      end else if (rdy) begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         len_q        <= len_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         mem_a_q      <= mem_a_d;
         mem_dout_q   <= mem_dout_d;
         mem_wr_q     <= mem_wr_d;
         if_done_q    <= if_done_d;
         lsb_done_q   <= lsb_done_d;
         if_data_q    <= if_data_d;
         lsb_rdata_q  <= lsb_rdata_d;
      end
   end

   assign if_done   = if_done_q;
   assign if_data   = if_data_q;
   assign lsb_done  = lsb_done_q;
   assign lsb_rdata = lsb_rdata_q;
   assign mem_dout  = mem_dout_q;
   assign mem_a     = mem_a_q;
   assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-wide RAM, byte-array reference model, vector table,
// hand-written corner sequences and randomized traffic.
module tb_mem_arbiter;

   localparam int RamWords = 262144;

   logic         clk = 1'b0;
   logic         rst, rdy, rollback;
   logic         if_valid, if_done;
   logic [31:0]  if_addr;
   logic [511:0] if_data;
   logic         lsb_valid, lsb_wr, lsb_done;
   logic [31:0]  lsb_addr, lsb_wdata, lsb_rdata;
   logic [1:0]   lsb_size;
   logic [7:0]   mem_din, mem_dout;
   logic [31:0]  mem_a;
   logic         mem_wr, io_buffer_full;

   logic [7:0]   ram       [RamWords];
   logic [7:0]   model_mem [RamWords];
   logic         ram_init, bd_we;
   logic [17:0]  bd_addr;
   logic [7:0]   bd_data;
   logic [39:0]  wr_log [$];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.BLK_BYTES(64), .IO_MASK(2'b11)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .if_valid(if_valid), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
      .lsb_valid(lsb_valid), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
      .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
      .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
      .io_buffer_full(io_buffer_full)
   );

   // RAM: combinational read of the registered address, write at the clock edge.
   assign mem_din = ram[mem_a[17:0]];

   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < RamWords; i++) ram[i] <= 8'(i);
      end else if (bd_we) begin
         ram[bd_addr] <= bd_data;
      end else if (rdy && mem_wr) begin
         ram[mem_a[17:0]] <= mem_dout;
      end
   end

   always @(negedge clk) if (mem_wr) wr_log.push_back({mem_a, mem_dout});

   initial begin
      #3000000;
      $display("FAIL watchdog: run did not finish, failures so far %0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [17:0] ra(input logic [31:0] a);
      return a[17:0];
   endfunction

   function automatic int len_of(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check512(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One LSB access; returns data and edges from request to done pulse.
   task automatic lsb_op(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata, input logic rb_first, input int rdy_gap,
                         output logic [31:0] rdata, output int lat);
      int   n, base, bad;
      logic got;
      n         = len_of(size);
      base      = wr_log.size();
      lsb_valid = 1'b1;
      lsb_wr    = wr;
      lsb_addr  = addr;
      lsb_size  = size;
      lsb_wdata = wdata;
      lat       = 0;
      got       = 1'b0;
      while (!got && lat < 200) begin
         rollback = rb_first && (lat == 0);
         rdy      = !(lat >= 2 && lat < 2 + rdy_gap);
         tick();
         lat++;
         got = lsb_done;
      end
      rollback  = 1'b0;
      rdy       = 1'b1;
      lsb_valid = 1'b0;
      rdata     = lsb_rdata;
      check32("mem_wr low at lsb_done", 32'(mem_wr), 32'd0);
      bad = 0;
      if (wr) begin
         if (wr_log.size() != base + n) bad++;
         else
            for (int k = 0; k < n; k++)
               if (wr_log[base + k] !== {addr + 32'(k), wdata[8*k +: 8]}) bad++;
         for (int k = 0; k < n; k++) model_mem[ra(addr + 32'(k))] = wdata[8*k +: 8];
      end else if (wr_log.size() != base) begin
         bad++;
      end
      check32($sformatf("write trace @%0h", addr), bad, 0);
      tick();
      check32("lsb_done single pulse", 32'(lsb_done), 32'd0);
   endtask

   // One block fill with an optional rollback pulse before edge rb_at+1.
   task automatic if_fill(input logic [31:0] base, input int rb_at);
      logic [511:0] exp;
      int           cyc, bad;
      logic         got;
      for (int i = 0; i < 64; i++) exp[8*i +: 8] = model_mem[ra(base + 32'(i))];
      if_valid = 1'b1;
      if_addr  = base;
      cyc      = 0;
      bad      = 0;
      got      = 1'b0;
      while (!got && cyc < 300) begin
         rollback = (rb_at > 0) && (cyc == rb_at);
         tick();
         rollback = 1'b0;
         cyc++;
         if (cyc <= 64 && mem_a !== base + 32'(cyc - 1)) bad++;
         got = if_done;
      end
      if_valid = 1'b0;
      check32($sformatf("fill %0h latency", base), cyc, 65);
      check32($sformatf("fill %0h mem_a walk", base), bad, 0);
      check512($sformatf("fill %0h data", base), if_data, exp);
      tick();
      check32("if_done single pulse", 32'(if_done), 32'd0);
   endtask

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   vec_t         vecs [10];
   int           ev [$];
   int           exp_ev [4];
   logic [31:0]  rd, exp32;
   logic [31:0]  rbase;
   logic [511:0] blk, exp_blk;
   int           lat, if_cyc, rb;
   logic         seen, got, wr;
   logic [1:0]   sz;

   initial begin
      vecs[0] = '{1'b0, 32'h200, 2'd2, 32'h0,        32'h44332211, 5};
      vecs[1] = '{1'b0, 32'h201, 2'd0, 32'h0,        32'h00000022, 2};
      vecs[2] = '{1'b0, 32'h202, 2'd1, 32'h0,        32'h00004433, 3};
      vecs[3] = '{1'b1, 32'h300, 2'd1, 32'h0000ABCD, 32'h0,        3};
      vecs[4] = '{1'b0, 32'h300, 2'd1, 32'h0,        32'h0000ABCD, 3};
      vecs[5] = '{1'b0, 32'h200, 2'd3, 32'h0,        32'h44332211, 5};
      vecs[6] = '{1'b1, 32'h310, 2'd0, 32'h0000005A, 32'h0,        2};
      vecs[7] = '{1'b0, 32'h310, 2'd2, 32'h0,        32'h1312115A, 5};
      vecs[8] = '{1'b1, 32'h320, 2'd2, 32'hDEADBEEF, 32'h0,        5};
      vecs[9] = '{1'b0, 32'h321, 2'd1, 32'h0,        32'h0000ADBE, 3};

      rst = 1'b0; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
      if_valid = 1'b0; if_addr = '0;
      lsb_valid = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_size = '0; lsb_wdata = '0;
      ram_init = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
      for (int i = 0; i < RamWords; i++) model_mem[i] = 8'(i);
      tick();
      ram_init = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bd_we   = 1'b1;
         bd_addr = 18'h200 + 18'(i);
         bd_data = 8'h11 * 8'(i + 1);
         model_mem[bd_addr] = bd_data;
         tick();
      end
      bd_we = 1'b0;

      // Reset held with both requests pending.
      if_valid = 1'b1; if_addr = 32'h1000;
      lsb_valid = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h200; lsb_size = 2'd2;
      for (int c = 0; c < 3; c++) begin
         tick();
         check32($sformatf("reset c%0d ctl", c), {21'b0, if_done, lsb_done, mem_wr, mem_dout},
                 32'd0);
         check32($sformatf("reset c%0d mem_a", c), mem_a, 32'd0);
         check32($sformatf("reset c%0d lsb_rdata", c), lsb_rdata, 32'd0);
         check512($sformatf("reset c%0d if_data", c), if_data, 512'd0);
      end

      // Contention: LSB wins the first tie, then strict alternation with a bubble.
      rst = 1'b1;
      for (int c = 1; c <= 143; c++) begin
         tick();
         if (lsb_done) ev.push_back(2 * c);
         if (if_done) ev.push_back(2 * c + 1);
      end
      if_valid = 1'b0; lsb_valid = 1'b0;
      tick(); tick();
      exp_ev = '{10, 143, 154, 287};
      check32("contention done count", ev.size(), 4);
      for (int k = 0; k < 4; k++)
         check32($sformatf("contention event %0d", k), (k < ev.size()) ? ev[k] : -1, exp_ev[k]);

      for (int i = 0; i < 10; i++) begin
         lsb_op(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, 1'b0, 0, rd, lat);
         check32($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
         if (!vecs[i].wr) check32($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      end

      if_fill(32'h1000, 0);
      if_fill(32'h1040, 20);

      // Rollback mid LS_READ after two bytes: abort, no done.
      lsb_valid = 1'b1; lsb_wr = 1'b0; lsb_addr = 32'h200; lsb_size = 2'd2;
      tick(); tick();
      rollback = 1'b1; lsb_valid = 1'b0;
      tick();
      rollback = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         if (lsb_done || mem_wr) seen = 1'b1;
         tick();
      end
      check32("rollback ls_read no done", 32'(seen), 32'd0);
      lsb_op(1'b0, 32'h201, 2'd0, 32'h0, 1'b0, 0, rd, lat);
      check32("post-rollback latency", lat, 2);
      check32("post-rollback rdata", rd, 32'h22);

      // Rollback in IDLE delays a load grant by one cycle.
      lsb_op(1'b0, 32'h203, 2'd0, 32'h0, 1'b1, 0, rd, lat);
      check32("idle rollback latency", lat, 3);
      check32("idle rollback rdata", rd, 32'h44);

      // rdy low for three cycles mid-load freezes progress.
      lsb_op(1'b0, 32'h200, 2'd2, 32'h0, 1'b0, 3, rd, lat);
      check32("rdy freeze latency", lat, 8);
      check32("rdy freeze rdata", rd, 32'h44332211);

      // IO store held off by a full buffer while a fill runs.
      io_buffer_full = 1'b1;
      lsb_valid = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h30000; lsb_size = 2'd0;
      lsb_wdata = 32'h77;
      if_valid = 1'b1; if_addr = 32'h2000;
      for (int i = 0; i < 64; i++) exp_blk[8*i +: 8] = model_mem[ra(32'h2000 + 32'(i))];
      seen = 1'b0; if_cyc = 0; blk = '0;
      for (int c = 1; c <= 80; c++) begin
         tick();
         if (lsb_done) seen = 1'b1;
         if (if_done) begin
            if_cyc   = c;
            blk      = if_data;
            if_valid = 1'b0;
         end
      end
      check32("io fill latency", if_cyc, 65);
      check512("io fill data", blk, exp_blk);
      check32("io store held", 32'(seen), 32'd0);
      io_buffer_full = 1'b0;
      lat = 0; got = 1'b0;
      while (!got && lat < 20) begin
         tick();
         lat++;
         got = lsb_done;
      end
      lsb_valid = 1'b0;
      model_mem[18'h30000] = 8'h77;
      check32("io store latency", lat, 2);
      tick();
      check32("io store ram", 32'(ram[18'h30000]), 32'(model_mem[18'h30000]));

      // Randomized traffic against the byte-array model.
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 7) == 0) begin
            rbase = 32'h4000 + (32'($urandom_range(0, 255)) << 6);
            if_fill(rbase, ($urandom_range(0, 1) == 1) ? $urandom_range(1, 63) : 0);
         end else begin
            wr    = 1'($urandom_range(0, 1));
            sz    = 2'($urandom_range(0, 3));
            rbase = 32'h5000 + 32'($urandom_range(0, 255));
            rb    = $urandom_range(0, 3) == 0 ? 1 : 0;
            exp32 = '0;
            for (int k = 0; k < len_of(sz); k++)
               exp32 = exp32 | (32'(model_mem[ra(rbase + 32'(k))]) << (8 * k));
            lsb_op(wr, rbase, sz, $urandom, 1'(rb), 0, rd, lat);
            check32($sformatf("rand%0d latency", t), lat,
                    len_of(sz) + 1 + ((rb == 1 && !wr) ? 1 : 0));
            if (!wr) check32($sformatf("rand%0d rdata @%0h", t, rbase), rd, exp32);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
